// File: rtl/acc_pkg.sv
// Shared widths and types for the product accumulator slice.
// The enum is for debug and assertion visibility only; it does not drive logic.
package acc_pkg;
  localparam int ACC_W_DEF = 19;
  localparam int PROD_W    = 16;

  typedef logic [ACC_W_DEF-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LAST  = 2'd2,
    STALL = 2'd3
  } acc_state_e;
endpackage

// File: rtl/acc_sat_add.sv
// ACC_W + PROD_W unsigned adder with carry-out.
// With ACC_SATURATE_EN defined the sum clamps to all-ones on carry, otherwise it wraps.
module acc_sat_add
  import acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_a,
  input  logic [PROD_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);
  logic [ACC_W:0] w_raw;

  assign w_raw   = {1'b0, i_a} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_b};
  assign o_carry = w_raw[ACC_W];

`ifdef ACC_SATURATE_EN
  assign o_sum = o_carry ? {ACC_W{1'b1}} : w_raw[ACC_W-1:0];
`else
  assign o_sum = w_raw[ACC_W-1:0];
`endif
endmodule

// File: rtl/product_accumulator.sv
// Sums NUM_TERMS consecutive products into a double-buffered valid/ready result.
// Optional clamp-on-overflow behaviour is selected by ACC_SATURATE_EN.
module product_accumulator
  import acc_pkg::*;
#(
  parameter  int NUM_TERMS = 8,
  parameter  int ACC_W     = ACC_W_DEF,
  localparam int CNT_W     = $clog2(NUM_TERMS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [15:0]       prod_in,
  output logic              in_ready,
  input  logic              clr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_out,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              ovf,
  output logic [1:0]        dbg_state
);
  // Handshake: a product transfers on a cycle with in_valid && in_ready; a result
  // transfers on a cycle with res_valid && res_ready. in_ready depends on res_ready
  // combinationally and only drops when the last term would overwrite an untaken result.

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_res_valid;
  logic             r_ovf;

  logic             w_last;
  logic             w_in_ready;
  logic             w_accept;
  logic [ACC_W-1:0] w_add_a;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  acc_state_e       w_state;

  assign w_last     = (r_cnt == CNT_W'(NUM_TERMS - 1));
  assign w_in_ready = !(w_last && r_res_valid && !res_ready);
  assign w_accept   = in_valid && w_in_ready && !clr;
  // The first term of a frame starts from zero, so the stale acc never leaks in.
  assign w_add_a    = (r_cnt == '0) ? '0 : r_acc;

  acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_a     (w_add_a),
    .i_b     (prod_in),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        if (w_carry) r_ovf <= 1'b1;
      end

      // A last term landing in the same cycle as the consumer take keeps res_valid high.
      if (w_accept && w_last) begin
        r_res       <= w_sum;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state = IDLE;
    if (r_cnt == '0)                        w_state = IDLE;
    else if (w_last && !w_in_ready)         w_state = STALL;
    else if (w_last)                        w_state = LAST;
    else                                    w_state = ACCUM;
  end

  assign in_ready  = w_in_ready;
  assign res_valid = r_res_valid;
  assign res_out   = r_res;
  assign term_cnt  = r_cnt;
  assign ovf       = r_ovf;
  assign dbg_state = w_state;
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 19-bit and a 16-bit instance share stimulus and
// are compared against a frame-list reference model.
module tb_product_accumulator;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] prod_in;
  logic        clr;
  logic        res_ready;

  logic        ir_a, rv_a, ovf_a;
  logic [18:0] ro_a;
  logic [1:0]  tc_a, st_a;
  logic        ir_b, rv_b, ovf_b;
  logic [15:0] ro_b;
  logic [1:0]  tc_b, st_b;

  int vectors     = 0;
  int miscompares = 0;

  int unsigned frame_q[$];
  bit          m_rv;
  longint      m_res19, m_res16;
  bit          m_ovf19, m_ovf16;

  always #5 clk = ~clk;

  product_accumulator #(.NUM_TERMS(N), .ACC_W(19)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .prod_in(prod_in),
    .in_ready(ir_a), .clr(clr), .res_valid(rv_a), .res_ready(res_ready),
    .res_out(ro_a), .term_cnt(tc_a), .ovf(ovf_a), .dbg_state(st_a)
  );

  product_accumulator #(.NUM_TERMS(N), .ACC_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .prod_in(prod_in),
    .in_ready(ir_b), .clr(clr), .res_valid(rv_b), .res_ready(res_ready),
    .res_out(ro_b), .term_cnt(tc_b), .ovf(ovf_b), .dbg_state(st_b)
  );

  function automatic longint reduce(longint total, int w);
    longint lim;
    lim = longint'(1) << w;
`ifdef ACC_SATURATE_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_rv    = 1'b0;
    m_res19 = 0;
    m_res16 = 0;
    m_ovf19 = 1'b0;
    m_ovf16 = 1'b0;
  endtask

  task automatic check_outputs();
    chk("res_valid19", rv_a, m_rv);
    chk("res_valid16", rv_b, m_rv);
    chk("res_out19", ro_a, m_res19);
    chk("res_out16", ro_b, m_res16);
    chk("term_cnt19", tc_a, frame_q.size());
    chk("term_cnt16", tc_b, frame_q.size());
    chk("ovf19", ovf_a, m_ovf19);
    chk("ovf16", ovf_b, m_ovf16);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    prod_in   = '0;
    clr       = 1'b0;
    res_ready = 1'b0;
    reset     = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("in_ready_rst", ir_a, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // One clock: drive inputs, check the combinational view, then the registered view.
  task automatic step(bit iv, int unsigned p, bit c, bit rr);
    bit     exp_ir, accept, done, consumed;
    int     exp_st;
    longint total;
    in_valid  = iv;
    prod_in   = p[15:0];
    clr       = c;
    res_ready = rr;
    #1;
    exp_ir = !(frame_q.size() == N - 1 && m_rv && !rr);
    if (frame_q.size() == 0)          exp_st = 0;
    else if (frame_q.size() == N - 1) exp_st = exp_ir ? 2 : 3;
    else                              exp_st = 1;
    chk("in_ready19", ir_a, exp_ir);
    chk("in_ready16", ir_b, exp_ir);
    chk("state19", st_a, exp_st);
    @(posedge clk);
    #1;
    accept   = iv && exp_ir && !c;
    consumed = m_rv && rr;
    done     = 1'b0;
    if (c) begin
      frame_q.delete();
    end else if (accept) begin
      frame_q.push_back(p);
      total = 0;
      foreach (frame_q[i]) total += frame_q[i];
      if (total >= (longint'(1) << 19)) m_ovf19 = 1'b1;
      if (total >= (longint'(1) << 16)) m_ovf16 = 1'b1;
      if (frame_q.size() == N) begin
        m_res19 = reduce(total, 19);
        m_res16 = reduce(total, 16);
        m_rv    = 1'b1;
        done    = 1'b1;
        frame_q.delete();
      end
    end
    if (consumed && !done) m_rv = 1'b0;
    check_outputs();
  endtask

  initial begin
    bit          s1_v, s2_v;
    int unsigned s1_p, s2_p;

    do_reset();

    // Reset mid-frame, then a clean frame of ones.
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    do_reset();
    chk("t1_in_ready", ir_a, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1);
    chk("t1_res", ro_a, 4);
    step(0, 0, 0, 1);

    // Basic frame.
    step(1, 3, 0, 1);
    step(1, 5, 0, 1);
    step(1, 7, 0, 1);
    step(1, 9, 0, 1);
    chk("t2_res", ro_a, 24);
    chk("t2_valid", rv_a, 1);
    chk("t2_cnt", tc_a, 0);
    step(0, 0, 0, 1);

    // Back-pressure on the last term, then simultaneous take and reload.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 2, 0, 0);
    step(1, 2, 0, 0);
    chk("t3_hold", ro_a, 4);
    chk("t3_cnt", tc_a, 3);
    step(1, 2, 0, 1);
    chk("t3_reload", ro_a, 8);
    chk("t3_valid", rv_a, 1);
    step(0, 0, 0, 1);

    // clr drops the partial sum and the product presented with it.
    step(1, 10, 0, 1);
    step(1, 20, 0, 1);
    step(1, 30, 1, 1);
    for (int i = 1; i <= 4; i++) step(1, i, 0, 1);
    chk("t4_res", ro_a, 10);
    step(0, 0, 0, 1);

    // Overflow on the 16-bit instance.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 16'hFFFF, 0, 1);
    chk("t5_ovf16", ovf_b, 1);
`ifdef ACC_SATURATE_EN
    chk("t5_res16", ro_b, 16'hFFFF);
`else
    chk("t5_res16", ro_b, 16'hFFFC);
`endif
    chk("t5_res19", ro_a, 262140);
    chk("t5_ovf19", ovf_a, 0);

    // Two-cycle multiplier feeding the accumulator with 255*255.
    do_reset();
    s1_v = 0; s1_p = 0; s2_v = 0; s2_p = 0;
    for (int k = 0; k < 6; k++) begin
      step(s2_v, s2_p, 0, 1);
      s2_v = s1_v;
      s2_p = s1_p;
      s1_v = (k < 4);
      s1_p = 255 * 255;
    end
    chk("t6_res", ro_a, 260100);
    chk("t6_valid", rv_a, 1);
    chk("t6_ovf", ovf_a, 0);
    step(0, 0, 0, 1);

    // Randomized traffic with occasional clr and a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 65535),
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
